// File: rtl/ds1302_pkg.sv
// rtl/ds1302_pkg.sv - shared constants, serial FSM states and BCD increment for the DS1302 responder
package ds1302_pkg;

  localparam logic [4:0] ADDR_SEC   = 5'd0;
  localparam logic [4:0] ADDR_MIN   = 5'd1;
  localparam logic [4:0] ADDR_HOUR  = 5'd2;
  localparam logic [4:0] ADDR_DATE  = 5'd3;
  localparam logic [4:0] ADDR_MONTH = 5'd4;
  localparam logic [4:0] ADDR_DAY   = 5'd5;
  localparam logic [4:0] ADDR_YEAR  = 5'd6;
  localparam logic [4:0] ADDR_WP    = 5'd7;
  localparam logic [4:0] ADDR_BURST = 5'd31;

  localparam int CMD_RD_BIT  = 0;
  localparam int CMD_RAM_BIT = 6;
  localparam int CMD_ONE_BIT = 7;

  localparam logic [7:0] RST_SEC   = 8'h80;
  localparam logic [7:0] RST_MIN   = 8'h00;
  localparam logic [7:0] RST_HOUR  = 8'h00;
  localparam logic [7:0] RST_DATE  = 8'h01;
  localparam logic [7:0] RST_MONTH = 8'h01;
  localparam logic [7:0] RST_DAY   = 8'h01;
  localparam logic [7:0] RST_YEAR  = 8'h00;
  localparam logic [7:0] RST_WP    = 8'h00;

  localparam logic [7:0] LIMIT_SEC  = 8'h59;
  localparam logic [7:0] LIMIT_MIN  = 8'h59;
  localparam logic [7:0] LIMIT_HOUR = 8'h23;

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA, ST_IGNORE} ser_state_e;

  // Returns {carry, next}; out-of-range values roll over to 00 like the limit itself.
  function automatic logic [8:0] bcd_inc(input logic [7:0] value, input logic [7:0] limit);
    logic [8:0] r;
    if (value >= limit) r = 9'h100;
    else if (value[3:0] >= 4'd9) r = {1'b0, value[7:4] + 4'd1, 4'd0};
    else r = {1'b0, value[7:4], value[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/ds1302_timekeeper.sv
// rtl/ds1302_timekeeper.sv - 1 Hz prescaler and sec/min/hour BCD chain with a write-port override
module ds1302_timekeeper
  import ds1302_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [7:0] hour_o,
  output logic       tick_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic          tick_q, tick_d;
  logic          wr_sec, wr_min, wr_hour, due;
  logic [8:0]    sec_inc, min_inc, hour_inc;

  always_comb begin
    pre_d    = pre_q;
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    tick_d   = 1'b0;
    wr_sec   = wr_en_i && (wr_addr_i == ADDR_SEC[2:0]);
    wr_min   = wr_en_i && (wr_addr_i == ADDR_MIN[2:0]);
    wr_hour  = wr_en_i && (wr_addr_i == ADDR_HOUR[2:0]);
    sec_inc  = bcd_inc(sec_q, LIMIT_SEC);
    min_inc  = bcd_inc(min_q, LIMIT_MIN);
    hour_inc = bcd_inc({1'b0, hour_q[6:0]}, LIMIT_HOUR);
    due      = !sec_q[7] && (pre_q == PRE_LAST);

    if (!sec_q[7]) pre_d = due ? '0 : pre_q + 1'b1;
    // A colliding write holds the prescaler at its last count so the tick lands one cycle later.
    if (due && (wr_sec || wr_min || wr_hour)) begin
      pre_d = pre_q;
    end else if (due) begin
      tick_d = 1'b1;
      sec_d  = sec_inc[7:0];
      if (sec_inc[8]) begin
        min_d = min_inc[7:0];
        if (min_inc[8]) hour_d = {hour_q[7], 7'h00} | (hour_inc[8] ? 8'h00 : hour_inc[7:0]);
      end
    end

    if (wr_sec) begin
      sec_d = wr_data_i;
      pre_d = '0;
    end
    if (wr_min)  min_d  = wr_data_i;
    if (wr_hour) hour_d = wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q  <= '0;
      sec_q  <= RST_SEC;
      min_q  <= RST_MIN;
      hour_q <= RST_HOUR;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      tick_q <= tick_d;
    end
  end

  assign sec_o  = sec_q;
  assign min_o  = min_q;
  assign hour_o = hour_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/ds1302_responder.sv
// rtl/ds1302_responder.sv - DS1302 3-wire slave: synchronisers, serial FSM, register file, tristate IO
module ds1302_responder
  import ds1302_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       ds1302_clk,
  input  logic       ds1302_rst,
  input  logic       ds1302_ce,
  input  logic       ds1302_sclk,
  inout  wire        ds1302_io,
  output logic [7:0] rtc_second,
  output logic [7:0] rtc_minute,
  output logic [7:0] rtc_hour,
  output logic       tick_1hz
);

  logic [SYNC_STAGES-1:0] ce_sync_q, sclk_sync_q, io_sync_q;
  logic ce_s, sclk_s, io_s, ce_prev_q, sclk_prev_q;
  logic ce_rise, sclk_rise, sclk_fall;

  ser_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d, addr_q, addr_d, tgt_idx;
  logic [3:0] byte_idx_q, byte_idx_d, wr_lim;
  logic       burst_q, burst_d, io_bit_q, io_bit_d, drive_q, drive_d, wr_en;
  logic [6:0] shift_q, shift_d;
  logic [7:0] out_q, out_d, in_byte, rd_byte;
  logic [7:0] date_q, date_d, month_q, month_d, day_q, day_d, year_q, year_d, wp_q, wp_d;

  assign ce_s      = ce_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign io_s      = io_sync_q[SYNC_STAGES-1];
  assign ce_rise   = ce_s && !ce_prev_q;
  assign sclk_rise = sclk_s && !sclk_prev_q;
  assign sclk_fall = !sclk_s && sclk_prev_q;

  // Gating with the synced CE releases the line before the FSM register catches up.
  assign ds1302_io = (drive_q && ce_s) ? io_bit_q : 1'bz;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    shift_d    = shift_q;
    out_d      = out_q;
    io_bit_d   = io_bit_q;
    drive_d    = drive_q;
    wr_en      = 1'b0;
    in_byte    = {io_s, shift_q};
    wr_lim     = burst_q ? 4'd8 : 4'd1;
    tgt_idx    = burst_q ? byte_idx_q[2:0] : addr_q;

    case (tgt_idx)
      ADDR_SEC[2:0]:   rd_byte = rtc_second;
      ADDR_MIN[2:0]:   rd_byte = rtc_minute;
      ADDR_HOUR[2:0]:  rd_byte = rtc_hour;
      ADDR_DATE[2:0]:  rd_byte = date_q;
      ADDR_MONTH[2:0]: rd_byte = month_q;
      ADDR_DAY[2:0]:   rd_byte = day_q;
      ADDR_YEAR[2:0]:  rd_byte = year_q;
      default:         rd_byte = wp_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (ce_rise) begin
          state_d    = ST_CMD;
          bit_cnt_d  = 3'd0;
          byte_idx_d = 4'd0;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          shift_d   = in_byte[7:1];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            burst_d = (in_byte[5:1] == ADDR_BURST);
            addr_d  = in_byte[3:1];
            if (!in_byte[CMD_ONE_BIT] || in_byte[CMD_RAM_BIT] ||
                (in_byte[5:1] > ADDR_WP && in_byte[5:1] != ADDR_BURST)) state_d = ST_IGNORE;
            else if (in_byte[CMD_RD_BIT]) state_d = ST_RDATA;
            else state_d = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (sclk_rise) begin
          shift_d   = in_byte[7:1];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7 && byte_idx_q < wr_lim) begin
            byte_idx_d = byte_idx_q + 4'd1;
            wr_en      = !wp_q[7] || (tgt_idx == ADDR_WP[2:0]);
          end
        end
      end
      ST_RDATA: begin
        if (sclk_fall) begin
          drive_d   = 1'b1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd0) begin
            io_bit_d = rd_byte[0];
            out_d    = {1'b0, rd_byte[7:1]};
          end else begin
            io_bit_d = out_q[0];
            out_d    = {1'b0, out_q[7:1]};
          end
          if (bit_cnt_q == 3'd7) byte_idx_d = {1'b0, byte_idx_q[2:0] + 3'd1};
        end
      end
      default: ;
    endcase

    if (!ce_s) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      byte_idx_d = 4'd0;
      drive_d    = 1'b0;
    end
  end

  always_comb begin
    date_d  = date_q;
    month_d = month_q;
    day_d   = day_q;
    year_d  = year_q;
    wp_d    = wp_q;
    if (wr_en) begin
      case (tgt_idx)
        ADDR_DATE[2:0]:  date_d  = in_byte;
        ADDR_MONTH[2:0]: month_d = in_byte;
        ADDR_DAY[2:0]:   day_d   = in_byte;
        ADDR_YEAR[2:0]:  year_d  = in_byte;
        ADDR_WP[2:0]:    wp_d    = in_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ds1302_clk or posedge ds1302_rst) begin
    if (ds1302_rst) begin
      ce_sync_q   <= '0;
      sclk_sync_q <= '0;
      io_sync_q   <= '0;
      ce_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= 4'd0;
      addr_q      <= 3'd0;
      burst_q     <= 1'b0;
      shift_q     <= 7'd0;
      out_q       <= 8'd0;
      io_bit_q    <= 1'b0;
      drive_q     <= 1'b0;
      date_q      <= RST_DATE;
      month_q     <= RST_MONTH;
      day_q       <= RST_DAY;
      year_q      <= RST_YEAR;
      wp_q        <= RST_WP;
    end else begin
      ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], ds1302_ce};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ds1302_sclk};
      io_sync_q   <= {io_sync_q[SYNC_STAGES-2:0], ds1302_io};
      ce_prev_q   <= ce_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      io_bit_q    <= io_bit_d;
      drive_q     <= drive_d;
      date_q      <= date_d;
      month_q     <= month_d;
      day_q       <= day_d;
      year_q      <= year_d;
      wp_q        <= wp_d;
    end
  end

  ds1302_timekeeper #(
    .TICK_DIV(TICK_DIV)
  ) u_timekeeper (
    .clk_i    (ds1302_clk),
    .rst_i    (ds1302_rst),
    .wr_en_i  (wr_en),
    .wr_addr_i(tgt_idx),
    .wr_data_i(in_byte),
    .sec_o    (rtc_second),
    .min_o    (rtc_minute),
    .hour_o   (rtc_hour),
    .tick_o   (tick_1hz)
  );

endmodule

// File: tb/tb_ds1302_responder.sv
// tb/tb_ds1302_responder.sv - randomized self-checking bench for ds1302_responder against a register-array model
module tb_ds1302_responder;

  localparam int TICK_DIV = 2000;
  localparam int H        = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic sclk = 1'b0;
  logic tb_en = 1'b0;
  logic tb_val = 1'b0;
  wire  io;
  logic [7:0] rtc_second, rtc_minute, rtc_hour;
  logic tick_1hz;

  assign io = tb_en ? tb_val : 1'bz;

  ds1302_responder #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(2)) dut (
    .ds1302_clk (clk),
    .ds1302_rst (rst),
    .ds1302_ce  (ce),
    .ds1302_sclk(sclk),
    .ds1302_io  (io),
    .rtc_second (rtc_second),
    .rtc_minute (rtc_minute),
    .rtc_hour   (rtc_hour),
    .tick_1hz   (tick_1hz)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int tick_seen = 0;
  longint cyc = 0;
  logic [7:0] model [8];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tick_1hz) tick_seen <= tick_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) << 4) + (n % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_xfer();
    sclk = 1'b0;
    ce = 1'b1;
    clks(H);
  endtask

  task automatic end_xfer();
    sclk = 1'b0;
    tb_en = 1'b0;
    ce = 1'b0;
    clks(H);
  endtask

  task automatic send_byte(input logic [7:0] b);
    tb_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tb_val = b[i];
      clks(H);
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end
    tb_en = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      clks(H);
      b[i] = (io === 1'b1);
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end
  endtask

  task automatic wr_reg(input int a, input logic [7:0] v);
    begin_xfer();
    send_byte(8'(8'h80 + 2 * a));
    send_byte(v);
    end_xfer();
    if (!model[7][7] || a == 7) model[a] = v;
  endtask

  task automatic rd_reg(input int a, output logic [7:0] v);
    begin_xfer();
    send_byte(8'(8'h81 + 2 * a));
    recv_byte(v);
    end_xfer();
  endtask

  task automatic wait_tick(output logic ok, output longint at);
    ok = 1'b0;
    at = 0;
    for (int c = 0; c < 3 * TICK_DIV; c++) begin
      @(negedge clk);
      if (tick_1hz) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic ok, seen;
    longint t [4];
    int secs, saved_snap;
    logic [7:0] saved;
    logic [7:0] burst_w [8];
    logic [7:0] ign_cmd [3];
    burst_w = '{8'h56, 8'h59, 8'h23, 8'h09, 8'h08, 8'h01, 8'h24, 8'h00};
    ign_cmd = '{8'h7F, 8'hC1, 8'h91};
    model = '{8'h80, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};

    clks(3);
    rst = 1'b0;
    clks(4);
    check("rst_sec", 32'(rtc_second), 32'(8'h80));
    check("rst_min", 32'(rtc_minute), 32'(8'h00));
    check("rst_hour", 32'(rtc_hour), 32'(8'h00));
    check("rst_tick", 32'(tick_1hz), 32'(1'b0));
    check("rst_io", 32'(io === 1'b1), 32'(1'b0));
    rd_reg(0, v);
    check("rd81", 32'(v), 32'(8'h80));
    clks(TICK_DIV + 100);
    check("halt_no_tick", 32'(tick_seen), 32'(0));

    wr_reg(7, 8'h00);
    begin_xfer();
    send_byte(8'hBE);
    for (int k = 0; k < 8; k++) send_byte(burst_w[k]);
    end_xfer();
    for (int k = 0; k < 8; k++) model[k] = burst_w[k];
    check("set_hour", 32'(rtc_hour), 32'(8'h23));
    check("set_min", 32'(rtc_minute), 32'(8'h59));
    check("set_sec", 32'(rtc_second), 32'(8'h56));

    for (int k = 0; k < 4; k++) begin
      wait_tick(ok, t[k]);
      check($sformatf("tick%0d_seen", k), 32'(ok), 32'(1'b1));
      if (k > 0) check($sformatf("tick%0d_period", k), 32'(t[k] - t[k-1]), 32'(TICK_DIV));
    end
    secs = (from_bcd(8'h23) * 3600 + from_bcd(8'h59) * 60 + from_bcd(8'h56) + 4) % 86400;
    model[0] = to_bcd(secs % 60);
    model[1] = to_bcd((secs / 60) % 60);
    model[2] = to_bcd(secs / 3600);
    check("roll_sec", 32'(rtc_second), 32'(model[0]));
    check("roll_min", 32'(rtc_minute), 32'(model[1]));
    check("roll_hour", 32'(rtc_hour), 32'(model[2]));
    rd_reg(3, v);
    check("roll_date", 32'(v), 32'(8'h09));

    wr_reg(0, 8'h80 | to_bcd($urandom_range(0, 59)));
    saved_snap = tick_seen;

    for (int it = 0; it < 24; it++) begin
      int a;
      logic [7:0] val;
      a = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) begin
        rd_reg(a, v);
        check($sformatf("rnd_rd%0d_it%0d", a, it), 32'(v), 32'(model[a]));
      end else begin
        val = 8'($urandom);
        if (a == 0) val[7] = 1'b1;
        if (a == 7) val = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
        wr_reg(a, val);
      end
    end
    check("rnd_sec", 32'(rtc_second), 32'(model[0]));
    check("rnd_min", 32'(rtc_minute), 32'(model[1]));
    check("rnd_hour", 32'(rtc_hour), 32'(model[2]));

    wr_reg(7, 8'h00);
    wr_reg(1, 8'h12);
    saved = model[1];
    wr_reg(7, 8'h80);
    wr_reg(1, 8'h30);
    check("wp_min_kept", 32'(rtc_minute), 32'(saved));
    wr_reg(7, 8'h00);
    rd_reg(7, v);
    check("wp_cleared", 32'(v), 32'(8'h00));

    begin_xfer();
    send_byte(8'hBF);
    for (int k = 0; k < 9; k++) begin
      recv_byte(v);
      check($sformatf("burst_rd%0d", k), 32'(v), 32'(model[k % 8]));
    end
    end_xfer();
    check("burst_rd_release", 32'(io === 1'b1), 32'(1'b0));

    wr_reg(4, 8'hFF);
    begin_xfer();
    send_byte(8'h89);
    clks(H);
    check("drive_bit0", 32'(io === 1'b1), 32'(1'b1));
    ce = 1'b0;
    clks(3);
    check("ce_release", 32'(io === 1'b1), 32'(1'b0));
    clks(H);

    begin_xfer();
    send_byte(8'h84);
    tb_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tb_val = 1'b1;
      clks(H);
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end
    end_xfer();
    check("abort_hour", 32'(rtc_hour), 32'(model[2]));
    wr_reg(2, 8'h15);
    check("after_abort_hour", 32'(rtc_hour), 32'(8'h15));

    for (int c = 0; c < 3; c++) begin
      begin_xfer();
      send_byte(ign_cmd[c]);
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
        clks(H);
        if (io === 1'b1) seen = 1'b1;
        sclk = 1'b1;
        clks(H);
        sclk = 1'b0;
      end
      end_xfer();
      check($sformatf("ign_%h_io", ign_cmd[c]), 32'(seen), 32'(1'b0));
    end
    begin_xfer(); send_byte(8'h90); send_byte(8'h00); end_xfer();
    check("ign_90_sec", 32'(rtc_second), 32'(model[0]));
    begin_xfer(); send_byte(8'h02); send_byte(8'hAA); end_xfer();
    begin_xfer(); send_byte(8'hC2); send_byte(8'hAA); end_xfer();
    check("ign_wr_min", 32'(rtc_minute), 32'(model[1]));
    check("halt_no_tick_end", 32'(tick_seen), 32'(saved_snap));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
